// File: rtl/amul_err_scan.sv
// Exhaustive scan engine for 8x8 approximate multipliers.
// It drives every operand pair and accumulates error metrics against the exact product.
module amul_err_scan #(
  parameter int PIPE  = 0,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      dut_prod,
  output logic             busy,
  output logic             done,
  output logic [16:0]      err_cnt,
  output logic [ACC_W-1:0] sum_ed,
  output logic [32:0]      sum_bias,
  output logic [15:0]      max_ed,
  output logic [7:0]       max_a,
  output logic [7:0]       max_b
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int DCW = $clog2(PIPE + 2) + 1;

  state_t          state, state_nxt;
  logic [15:0]     idx;
  logic [DCW-1:0]  drain_cnt;
  logic            issue_v;
  logic            accept;

  logic            tap_v;
  logic [7:0]      tap_a, tap_b;

  logic            cmp_v;
  logic [7:0]      cmp_a, cmp_b;
  logic [15:0]     cmp_exact, cmp_prod;

  logic [16:0]     diff;
  logic [15:0]     ed;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign busy   = (state == RUN) || (state == DRAIN);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN:        if (idx == 16'hFFFF) state_nxt = DRAIN;
      DRAIN:      if (drain_cnt == DCW'(PIPE + 1)) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= 16'd0;
      mul_a     <= 8'd0;
      mul_b     <= 8'd0;
      issue_v   <= 1'b0;
      drain_cnt <= '0;
    end else begin
      issue_v <= 1'b0;
      if (accept) begin
        idx       <= 16'd0;
        drain_cnt <= '0;
      end else if (state == RUN) begin
        mul_a   <= idx[15:8];
        mul_b   <= idx[7:0];
        issue_v <= 1'b1;
        idx     <= idx + 16'd1;
      end else if (state == DRAIN) begin
        drain_cnt <= drain_cnt + DCW'(1);
      end
    end
  end

  // Operand tags travel alongside the multiplier pipeline so each product meets its own pair.
  generate
    if (PIPE == 0) begin : g_nodly
      assign tap_v = issue_v;
      assign tap_a = mul_a;
      assign tap_b = mul_b;
    end else begin : g_dly
      logic       dv [PIPE];
      logic [7:0] da [PIPE];
      logic [7:0] db [PIPE];

      always_ff @(posedge clk) begin
        if (!rst_n || accept) begin
          for (int i = 0; i < PIPE; i++) begin
            dv[i] <= 1'b0;
            da[i] <= 8'd0;
            db[i] <= 8'd0;
          end
        end else begin
          dv[0] <= issue_v;
          da[0] <= mul_a;
          db[0] <= mul_b;
          for (int i = 1; i < PIPE; i++) begin
            dv[i] <= dv[i-1];
            da[i] <= da[i-1];
            db[i] <= db[i-1];
          end
        end
      end

      assign tap_v = dv[PIPE-1];
      assign tap_a = da[PIPE-1];
      assign tap_b = db[PIPE-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      cmp_v     <= 1'b0;
      cmp_a     <= 8'd0;
      cmp_b     <= 8'd0;
      cmp_exact <= 16'd0;
      cmp_prod  <= 16'd0;
    end else begin
      cmp_v     <= tap_v;
      cmp_a     <= tap_a;
      cmp_b     <= tap_b;
      cmp_exact <= 16'(tap_a) * 16'(tap_b);
      cmp_prod  <= dut_prod;
    end
  end

  assign diff = {1'b0, cmp_prod} - {1'b0, cmp_exact};
  assign ed   = diff[16] ? 16'(-diff) : diff[15:0];

  // Strict comparison keeps the earliest pair in scan order on ties.
  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      err_cnt  <= 17'd0;
      sum_ed   <= '0;
      sum_bias <= 33'd0;
      max_ed   <= 16'd0;
      max_a    <= 8'd0;
      max_b    <= 8'd0;
    end else if (cmp_v) begin
      err_cnt  <= err_cnt + 17'(ed != 16'd0);
      sum_ed   <= sum_ed + ACC_W'(ed);
      sum_bias <= sum_bias + {{16{diff[16]}}, diff};
      if (ed > max_ed) begin
        max_ed <= ed;
        max_a  <= cmp_a;
        max_b  <= cmp_b;
      end
    end
  end

endmodule

// File: tb/tb_amul_err_scan.sv
// Bench for amul_err_scan: several scanners run in parallel against different multipliers
// and are checked against error metrics computed directly over all operand pairs.
module tb_amul_err_scan;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  always #5 clk = ~clk;

  logic [7:0]  mulA    [6];
  logic [7:0]  mulB    [6];
  logic [15:0] prod    [6];
  logic        busy    [6];
  logic        done    [6];
  logic [16:0] errCnt  [6];
  logic [31:0] sumEd   [6];
  logic [32:0] sumBias [6];
  logic [15:0] maxEd   [6];
  logic [7:0]  maxA    [6];
  logic [7:0]  maxB    [6];

  logic [15:0] pipeApx [3];
  logic [15:0] pipeExA [3];
  logic [15:0] pipeExB [3];

  logic [7:0]  salt  = 8'd0;
  logic [15:0] tmask = 16'd0;
  logic [15:0] bump  = 16'd0;

  int tests    = 0;
  int failures = 0;

  longint expErr [5];
  longint expSed [5];
  longint expSb  [5];
  int     expMe  [5];
  int     expMa  [5];
  int     expMb  [5];

  // Multiplier flavours: 0 exact, 1 tied to zero, 2 exact plus one, 3 randomised approximation.
  function automatic logic [15:0] prodFn(input int kind, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (kind)
      1: p = 16'd0;
      2: p = p + 16'd1;
      3: begin
        p = p & ~tmask;
        if (((a ^ b ^ salt) & 8'h07) == 8'h00) p = p + bump;
      end
      default: ;
    endcase
    return p;
  endfunction

  genvar g;
  generate
    for (g = 0; g < 6; g++) begin : g_dut
      amul_err_scan #(
        .PIPE ((g == 3 || g == 4) ? 3 : ((g == 5) ? 2 : 0)),
        .ACC_W(32)
      ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .mul_a   (mulA[g]),
        .mul_b   (mulB[g]),
        .dut_prod(prod[g]),
        .busy    (busy[g]),
        .done    (done[g]),
        .err_cnt (errCnt[g]),
        .sum_ed  (sumEd[g]),
        .sum_bias(sumBias[g]),
        .max_ed  (maxEd[g]),
        .max_a   (maxA[g]),
        .max_b   (maxB[g])
      );
    end
  endgenerate

  assign prod[0] = prodFn(0, mulA[0], mulB[0]);
  assign prod[1] = prodFn(1, mulA[1], mulB[1]);
  assign prod[2] = prodFn(2, mulA[2], mulB[2]);
  assign prod[3] = pipeApx[2];
  assign prod[4] = pipeExA[2];
  assign prod[5] = pipeExB[2];

  // Three-stage multipliers; instance 5 is deliberately configured for two stages.
  always @(posedge clk) begin
    pipeApx[0] <= prodFn(3, mulA[3], mulB[3]);
    pipeApx[1] <= pipeApx[0];
    pipeApx[2] <= pipeApx[1];
    pipeExA[0] <= prodFn(0, mulA[4], mulB[4]);
    pipeExA[1] <= pipeExA[0];
    pipeExA[2] <= pipeExA[1];
    pipeExB[0] <= prodFn(0, mulA[5], mulB[5]);
    pipeExB[1] <= pipeExB[0];
    pipeExB[2] <= pipeExB[1];
  end

  task automatic computeModel(input int slot, input int kind);
    longint ec, se, sb;
    int me, ma, mb, ex, d, ad;
    ec = 0; se = 0; sb = 0; me = 0; ma = 0; mb = 0;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        ex = a * b;
        d  = int'(prodFn(kind, 8'(a), 8'(b))) - ex;
        ad = (d < 0) ? -d : d;
        if (ad != 0) ec++;
        se += ad;
        sb += d;
        if (ad > me) begin
          me = ad; ma = a; mb = b;
        end
      end
    end
    expErr[slot] = ec; expSed[slot] = se; expSb[slot] = sb;
    expMe[slot]  = me; expMa[slot]  = ma; expMb[slot] = mb;
  endtask

  task automatic applyStimulus(input logic st, input logic rn, input int cycles);
    start = st;
    rst_n = rn;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int d0, d3;
    logic [32:0] sbExp;

    salt  = 8'($urandom);
    tmask = 16'($urandom_range(1, 15));
    bump  = 16'($urandom_range(1, 300));
    $display("[TB] approx model salt=%0d tmask=%0d bump=%0d", salt, tmask, bump);
    computeModel(0, 0);
    computeModel(1, 1);
    computeModel(2, 2);
    computeModel(3, 3);
    computeModel(4, 0);

    applyStimulus(1'b0, 1'b0, 3);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("rst_busy[%0d]", i), 64'(busy[i]), 64'd0);
      checkOutput($sformatf("rst_done[%0d]", i), 64'(done[i]), 64'd0);
    end
    checkOutput("rst_err_cnt", 64'(errCnt[0]), 64'd0);
    checkOutput("rst_mul_ab", 64'({mulA[0], mulB[0]}), 64'd0);

    // Partial scan: a start pulse mid-run must not restart the operand sequence.
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("busy_after_start", 64'(busy[0]), 64'd1);
    applyStimulus(1'b0, 1'b1, 499);
    checkOutput("idx_at_499", 64'({mulA[0], mulB[0]}), 64'd498);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("idx_after_ignored_start", 64'({mulA[0], mulB[0]}), 64'd499);
    applyStimulus(1'b0, 1'b1, 500);
    checkOutput("idx_at_1000", 64'({mulA[0], mulB[0]}), 64'd999);
    checkOutput("live_err_cnt_plus1", 64'(errCnt[2]), 64'd998);

    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("abort_busy", 64'(busy[1]), 64'd0);
    checkOutput("abort_done", 64'(done[1]), 64'd0);
    checkOutput("abort_mul_ab", 64'({mulA[1], mulB[1]}), 64'd0);
    checkOutput("abort_err_cnt", 64'(errCnt[1]), 64'd0);
    checkOutput("abort_sum_ed", 64'(sumEd[1]), 64'd0);
    checkOutput("abort_sum_bias", 64'(sumBias[1]), 64'd0);
    checkOutput("abort_max", 64'({maxEd[1], maxA[1], maxB[1]}), 64'd0);
    applyStimulus(1'b0, 1'b1, 2);
    checkOutput("idle_stays_idle", 64'(busy[0]), 64'd0);

    // Full scan on every instance at once.
    applyStimulus(1'b1, 1'b1, 1);
    d0 = 0;
    d3 = 0;
    for (int cyc = 1; cyc <= 70000; cyc++) begin
      applyStimulus(1'b0, 1'b1, 1);
      if (cyc == 65537) checkOutput("busy_before_done", 64'(busy[0]), 64'd1);
      if (done[0] && d0 == 0) d0 = cyc;
      if (done[4] && d3 == 0) d3 = cyc;
      if (d0 != 0 && d3 != 0) break;
    end
    checkOutput("done_latency_pipe0", 64'(d0), 64'd65538);
    checkOutput("done_latency_pipe3", 64'(d3), 64'd65541);
    checkOutput("busy_at_done", 64'(busy[0]), 64'd0);

    for (int i = 0; i < 5; i++) begin
      sbExp = 33'(expSb[i]);
      checkOutput($sformatf("done[%0d]", i), 64'(done[i]), 64'd1);
      checkOutput($sformatf("err_cnt[%0d]", i), 64'(errCnt[i]), 64'(expErr[i]));
      checkOutput($sformatf("sum_ed[%0d]", i), 64'(sumEd[i]), 64'(32'(expSed[i])));
      checkOutput($sformatf("sum_bias[%0d]", i), 64'(sumBias[i]), 64'(sbExp));
      checkOutput($sformatf("max_ed[%0d]", i), 64'(maxEd[i]), 64'(expMe[i]));
      checkOutput($sformatf("max_a[%0d]", i), 64'(maxA[i]), 64'(expMa[i]));
      checkOutput($sformatf("max_b[%0d]", i), 64'(maxB[i]), 64'(expMb[i]));
    end
    checkOutput("misaligned_pipe_errs", 64'(errCnt[5] != 17'd0), 64'd1);

    // Restart from DONE clears everything and begins a fresh scan.
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("restart_done_low", 64'(done[1]), 64'd0);
    checkOutput("restart_busy", 64'(busy[1]), 64'd1);
    checkOutput("restart_err_cnt", 64'(errCnt[1]), 64'd0);
    checkOutput("restart_sum_ed", 64'(sumEd[1]), 64'd0);
    checkOutput("restart_max", 64'({maxEd[1], maxA[1], maxB[1]}), 64'd0);
    applyStimulus(1'b0, 1'b1, 300);
    checkOutput("rerun_idx", 64'({mulA[2], mulB[2]}), 64'd299);
    checkOutput("rerun_err_cnt_plus1", 64'(errCnt[2]), 64'd298);
    checkOutput("rerun_sum_ed_plus1", 64'(sumEd[2]), 64'd298);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/amul_err_scan.md
Name: amul_err_scan

Overview:
- Sequential stimulus/characterisation engine for the 8x8 approximate multipliers.
- Drives every operand pair (a,b) in 0..255 x 0..255 into an attached multiplier under test and samples its 16-bit product.
- Computes the exact product internally and accumulates error metrics: error count, sum of error distance, signed bias sum, and maximum error distance with its operands.
- Sits on the multiplier's input/output interface as the driving and checking end, replacing exhaustive testbench loops on FPGA.

Parameters:
- PIPE, 0, register stages inside the multiplier under test between mul_a/mul_b and dut_prod (0 = combinational).
- ACC_W, 32, width of sum_ed; 32 covers the worst case 65536 x 65535.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse; begins a scan when idle.
- mul_a  output  8  operand a to the multiplier under test.
- mul_b  output  8  operand b to the multiplier under test.
- dut_prod  input  16  product returned by the multiplier under test.
- busy  output  1  high from the start acceptance until done.
- done  output  1  high once results are final; held until next accepted start.
- err_cnt  output  17  number of pairs with dut_prod != a*b.
- sum_ed  output  ACC_W  sum of |dut_prod - a*b|.
- sum_bias  output  33  signed sum of (dut_prod - a*b), two's complement.
- max_ed  output  16  largest |dut_prod - a*b|.
- max_a  output  8  a at first occurrence of max_ed.
- max_b  output  8  b at first occurrence of max_ed.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State IDLE; mul_a, mul_b, busy, done and all result registers cleared to 0.
  - Applies mid-scan: the scan is aborted and no partial result is retained.
- States: IDLE -> RUN -> DRAIN -> DONE; DONE -> RUN on start.
- Start handling:
  - start in IDLE or DONE: clear all accumulators, done=0, busy=1, index idx=0, go to RUN.
  - start while busy is ignored.
- RUN operand sequence:
  - mul_a=idx[15:8], mul_b=idx[7:0], registered outputs; idx increments by 1 each cycle.
  - After idx=16'hFFFF is presented, go to DRAIN; idx wrap to 0 is not issued.
- Operand tracking:
  - A valid/operand delay line of PIPE stages tracks each issued pair so that dut_prod is matched to its operands.
  - The matched pair is captured in a compare register together with exact = a*b (16-bit unsigned).
- Accumulation:
  - Occurs the cycle after compare capture: diff = dut_prod - exact as 17-bit signed; ed = |diff| (16-bit).
  - err_cnt += (ed != 0); sum_ed += ed; sum_bias += sign-extended diff.
  - If ed > max_ed (strictly greater), update max_ed, max_a, max_b. Ties keep the earliest pair in scan order.
  - Initial max_ed = 0, max_a = 0, max_b = 0, so an exact multiplier reports 0/0/0.
- DRAIN: lasts PIPE+2 cycles to flush the delay line, compare and accumulate stages, then go to DONE with busy=0, done=1.
- Latency: start accepted at edge 0 -> done=1 after edge 65536+PIPE+2. Total scan 65538+PIPE cycles.
- Result outputs: update live during RUN; final and stable only while done=1.
- No saturation: widths are sized so overflow cannot occur.

Test Plan:
- Exact DUT (dut_prod = a*b), PIPE=0, start pulse -> done exactly 65538 cycles after start; err_cnt=0, sum_ed=0, sum_bias=0, max_ed=0, max_a=0, max_b=0.
- DUT tied to 0 -> err_cnt=65025, sum_ed=1065369600, sum_bias=-1065369600, max_ed=65025, max_a=255, max_b=255.
- DUT = a*b+1 -> err_cnt=65536, sum_ed=65536, sum_bias=65536, max_ed=1, max_a=0, max_b=0 (first-occurrence tie rule).
- Exact DUT behind 3 register stages, PIPE=3 -> same zero results as the exact-DUT case; done at 65541 cycles; a wrong PIPE setting yields nonzero err_cnt, confirming alignment.
- Reset and start handling:
  - Assert rst_n=0 at idx=1000 -> next cycle all outputs 0, state IDLE.
  - Fresh start -> full correct results.
  - start pulsed mid-RUN -> ignored; idx is not restarted.
- Back-to-back runs: start again while done=1 -> done drops next cycle, accumulators cleared, and the second run reproduces identical results.
